// File: rtl/io2_display.sv
// io2_display: eight-digit multiplexed seven-segment driver for the IO2
// output register. It shows the CPU value as hex or as unsigned decimal. The
// decimal path uses a serial shift-add-3 converter that takes 32 cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_in    32-bit value written by the CPU
//   data_valid one-cycle strobe marking a new data_in
//   mode_dec   1 = unsigned decimal, 0 = hex; sampled with data_valid
//   seg        active-low segments {g,f,e,d,c,b,a}
//   an         active-low one-hot digit anodes, bit 0 = rightmost digit
//   busy       high while a decimal conversion runs or is queued
module io2_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   input  logic        mode_dec,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        busy
);

   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t          state, state_nx;
   logic [RW-1:0]   refresh_cnt;
   logic [2:0]      digit_idx;

   logic [31:0]     conv_bin;
   logic [39:0]     conv_bcd;
   logic [4:0]      conv_cnt;
   // Set for one CONVERT cycle in which the pending slot is consumed instead
   // of shifting the converter.
   logic            start_pend;

   logic            pend_full;
   logic [31:0]     pend_data;
   logic            pend_dec;

   logic [31:0]     disp_digits;
   logic            disp_dec;
   logic            disp_ovf;

   logic [71:0]     step_nx;
   logic            ld_conv_idle, ld_conv_pend, shift_en, commit_dec;
   logic            commit_hex_idle, commit_hex_pend, pend_wr;
   logic [3:0]      cur_digit;
   logic            blank;

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
   // whole {bcd, bin} chain left by one bit.
   function automatic logic [71:0] bcd_step(input logic [39:0] bcd,
                                            input logic [31:0] bin);
      logic [39:0] adj;
      adj = bcd;
      for (int i = 0; i < 10; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      return {adj[38:0], bin, 1'b0};
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   assign step_nx         = bcd_step(conv_bcd, conv_bin);
   assign ld_conv_idle    = (state == IDLE) && data_valid && mode_dec;
   assign commit_hex_idle = (state == IDLE) && data_valid && !mode_dec;
   assign ld_conv_pend    = (state == CONVERT) && start_pend && pend_dec;
   assign commit_hex_pend = (state == CONVERT) && start_pend && !pend_dec;
   assign shift_en        = (state == CONVERT) && !start_pend;
   assign commit_dec      = shift_en && (conv_cnt == 5'd31);
   assign pend_wr         = (state == CONVERT) && data_valid;
   assign busy            = (state == CONVERT);

   // ---- FSM state register ----
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // ---- FSM next state ----
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (data_valid && mode_dec)
               state_nx = CONVERT;
         end
         CONVERT: begin
            // Leave only when nothing is left to do, counting a strobe that
            // arrives on this very edge as pending work.
            if (start_pend) begin
               if (!pend_dec && !data_valid)
                  state_nx = IDLE;
            end else if (conv_cnt == 5'd31 && !pend_full && !data_valid) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---- control, scan and display register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= 3'd0;
         conv_cnt    <= 5'd0;
         start_pend  <= 1'b0;
         pend_full   <= 1'b0;
         disp_digits <= 32'd0;
         disp_dec    <= 1'b0;
         disp_ovf    <= 1'b0;
      end else begin
         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 3'd1;
         end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
         end

         if (ld_conv_idle || ld_conv_pend)
            conv_cnt <= 5'd0;
         else if (shift_en)
            conv_cnt <= conv_cnt + 5'd1;

         if (commit_dec)
            start_pend <= pend_full || data_valid;
         else if (state == CONVERT && start_pend)
            start_pend <= commit_hex_pend && data_valid;

         if (pend_wr)
            pend_full <= 1'b1;
         else if (state == CONVERT && start_pend)
            pend_full <= 1'b0;

         if (commit_hex_idle) begin
            disp_digits <= data_in;
            disp_dec    <= 1'b0;
            disp_ovf    <= 1'b0;
         end else if (commit_hex_pend) begin
            disp_digits <= pend_data;
            disp_dec    <= 1'b0;
            disp_ovf    <= 1'b0;
         end else if (commit_dec) begin
            // The top two BCD digits only matter as an out-of-range flag.
            disp_digits <= step_nx[63:32];
            disp_dec    <= 1'b1;
            disp_ovf    <= |step_nx[71:64];
         end
      end
   end

   // ---- converter and pending-slot data ----
   always_ff @(posedge clk) begin
      if (ld_conv_idle) begin
         conv_bin <= data_in;
         conv_bcd <= 40'd0;
      end else if (ld_conv_pend) begin
         conv_bin <= pend_data;
         conv_bcd <= 40'd0;
      end else if (shift_en) begin
         conv_bcd <= step_nx[71:32];
         conv_bin <= step_nx[31:0];
      end

      if (pend_wr) begin
         pend_data <= data_in;
         pend_dec  <= mode_dec;
      end
   end

   // ---- segment / anode decode ----
   assign cur_digit = disp_digits[{digit_idx, 2'b00} +: 4];
   // A decimal digit is a leading zero when it and every digit above it are
   // zero; digit 0 is never blanked.
   assign blank = disp_dec && (digit_idx != 3'd0) &&
                  ((disp_digits >> {digit_idx, 2'b00}) == 32'd0);

   always_comb begin
      seg = glyph(cur_digit);
      an  = ~(8'b1 << digit_idx);
      if (disp_ovf)
         seg = 7'h3F;
      else if (blank)
         seg = 7'h7F;
      if (rst) begin
         seg = 7'h7F;
         an  = 8'hFF;
      end
   end

endmodule

// File: tb/tb_io2_display.sv
// tb_io2_display: self-checking bench for io2_display with REFRESH_DIV = 4.
// A table of hand-computed vectors, hand-written multi-cycle sequences and
// randomized values checked against an arithmetic reference model.
module tb_io2_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic        data_valid;
   logic        mode_dec;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic        busy;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   typedef logic [7:0][6:0] disp_t;
   typedef struct {
      logic [31:0] data;
      logic        dec;
      disp_t       exp;
      string       name;
   } vec_t;

   localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                       7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                       7'h46, 7'h21, 7'h06, 7'h0E};

   disp_t cur_exp;
   vec_t  tbl [8];

   io2_display #(.REFRESH_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .mode_dec   (mode_dec),
      .seg        (seg),
      .an         (an),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference display contents from plain arithmetic on the value.
   function automatic disp_t model_vec(input logic [31:0] v, input logic dec);
      disp_t  r;
      longint lv;
      longint p;
      lv = longint'(v);
      p  = 1;
      for (int i = 0; i < 8; i++) begin
         if (!dec)
            r[i] = GLY[(lv >> (4 * i)) & 15];
         else if (lv > 99999999)
            r[i] = 7'h3F;
         else if (i != 0 && lv < p)
            r[i] = 7'h7F;
         else
            r[i] = GLY[(lv / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare the segments of whichever digit is currently scanned.
   task automatic check_now(input disp_t exp, input string nm);
      int idx;
      idx = -1;
      for (int i = 0; i < 8; i++)
         if (an == ~(8'b1 << i)) idx = i;
      if (idx < 0)
         cmp({nm, "_an_onehot"}, {24'd0, an}, 32'hFE);
      else
         cmp(nm, {25'd0, seg}, {25'd0, exp[idx]});
   endtask

   // Called at a negedge; covers one full scan period.
   task automatic check_disp(input disp_t exp, input string nm);
      for (int k = 0; k < 32; k++) begin
         check_now(exp, nm);
         @(negedge clk);
      end
   endtask

   task automatic apply(input logic [31:0] v, input logic dec, input disp_t exp,
                        input string nm);
      int n;
      @(posedge clk);
      #1;
      data_in    = v;
      mode_dec   = dec;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      if (dec) begin
         n = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            check_now(cur_exp, {nm, "_old"});
         end
         cmp({nm, "_latency"}, n, 32);
      end else begin
         @(negedge clk);
         cmp({nm, "_busy"}, {31'd0, busy}, 32'd0);
      end
      cur_exp = exp;
      check_disp(exp, nm);
   endtask

   initial begin
      tbl[0] = '{32'd42,         1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, "dec42"};
      tbl[1] = '{32'hDEADBEEF,   1'b0, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, "hex_deadbeef"};
      tbl[2] = '{32'd100000000,  1'b1, {8{7'h3F}},                                                "dec_over"};
      tbl[3] = '{32'd99999999,   1'b1, {8{7'h10}},                                                "dec_max8"};
      tbl[4] = '{32'h01234567,   1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, "hex_01234567"};
      tbl[5] = '{32'd0,          1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "dec_zero"};
      tbl[6] = '{32'hFFFFFFFF,   1'b1, {8{7'h3F}},                                                "dec_umax"};
      tbl[7] = '{32'd12345,      1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, "dec12345"};

      rst        = 1'b1;
      data_in    = 32'd0;
      data_valid = 1'b0;
      mode_dec   = 1'b0;
      cur_exp    = {8{7'h40}};

      // Reset behaviour and scan sequence
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("rst_an", {24'd0, an}, 32'hFF);
      cmp("rst_seg", {25'd0, seg}, 32'h7F);
      cmp("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         cmp("scan_an", {24'd0, an}, {24'd0, ~(8'b1 << ((k / 4) % 8))});
         check_now(cur_exp, "scan_seg");
      end

      // Table of fixed vectors
      for (int i = 0; i < 8; i++)
         apply(tbl[i].data, tbl[i].dec, tbl[i].exp, tbl[i].name);

      // Pending slot: 5 at T, 7 at T+3, 9 at T+5; 7 is overwritten
      @(posedge clk);
      #1;
      data_in = 32'd5; mode_dec = 1'b1; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      tick();
      data_in = 32'd7; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      data_in = 32'd9; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int m = 5; m <= 70; m++) begin
         @(negedge clk);
         cmp("pend_busy", {31'd0, busy}, {31'd0, (m < 65)});
         if (m < 32)
            check_now(cur_exp, "pend_old");
         else if (m < 65)
            check_now(model_vec(32'd5, 1'b1), "pend_first");
         else
            check_now(model_vec(32'd9, 1'b1), "pend_last");
      end
      cur_exp = model_vec(32'd9, 1'b1);

      // Pending hex value behind a decimal conversion
      @(posedge clk);
      #1;
      data_in = 32'd77; mode_dec = 1'b1; data_valid = 1'b1;
      tick();
      data_in = 32'hCAFE0123; mode_dec = 1'b0;
      tick();
      data_valid = 1'b0;
      for (int m = 1; m <= 40; m++) begin
         @(negedge clk);
         cmp("pendhex_busy", {31'd0, busy}, {31'd0, (m < 33)});
         if (m == 32)
            check_now(model_vec(32'd77, 1'b1), "pendhex_dec");
         else if (m >= 33)
            check_now(model_vec(32'hCAFE0123, 1'b0), "pendhex_hex");
      end
      cur_exp = model_vec(32'hCAFE0123, 1'b0);

      // Reset in the middle of a conversion
      apply(32'h00000077, 1'b0, model_vec(32'h00000077, 1'b0), "pre_rst_hex");
      @(posedge clk);
      #1;
      data_in = 32'd123; mode_dec = 1'b1; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      @(negedge clk);
      cmp("midrst_an", {24'd0, an}, 32'hFF);
      cmp("midrst_seg", {25'd0, seg}, 32'h7F);
      tick();
      rst = 1'b0;
      cur_exp = {8{7'h40}};
      @(negedge clk);
      cmp("postrst_an", {24'd0, an}, 32'hFE);
      for (int m = 0; m < 45; m++) begin
         cmp("postrst_busy", {31'd0, busy}, 32'd0);
         check_now(cur_exp, "postrst_seg");
         @(negedge clk);
      end

      // Randomized values against the reference model
      for (int r = 0; r < 24; r++) begin
         logic [31:0] v;
         logic        d;
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 999);
            2: v = $urandom_range(99999990, 100000010);
            default: v = $urandom_range(0, 99999999);
         endcase
         d = 1'($urandom_range(0, 1));
         apply(v, d, model_vec(v, d), d ? "rand_dec" : "rand_hex");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
